queue_ctrl_1r_1w: RTL

- Pointer/flow-control sequencer for the parameterised 1-read/1-write register-file queue storage.
- Turns a raw addressed array into a FIFO: keeps head/tail pointers and occupancy, and drives the storage write enable, write address and read address.
- Gives valid/ready handshakes on the push and pop sides. Used wherever a wavefront/instruction buffer needs in-order buffering.
- Storage is instantiated alongside, not inside. Read data reaches the consumer straight from the storage read mux.

---
 rtl/queue_ctrl_1r_1w_pkg.sv | 26 ++
 rtl/queue_ptr_ctr.sv | 39 +++
 rtl/queue_ctrl_1r_1w.sv | 110 +++++++++++
 3 files changed

// File: rtl/queue_ctrl_1r_1w_pkg.sv
// Shared helpers for the 1R/1W queue sequencer.
// Pointer wrap at SIZE-1 and occupancy width (BITS+1).
package queue_ctrl_1r_1w_pkg;

  localparam int unsigned CNT_EXTRA = 1;

  function automatic int unsigned cnt_width(
    input int unsigned bits
  );
    return bits + CNT_EXTRA;
  endfunction

  // Wrap at SIZE-1 so non-power-of-two depths never reach spare codes
  function automatic int unsigned ptr_inc(
    input int unsigned ptr,
    input int unsigned size
  );
    int unsigned nxt;
    nxt = ptr + 1;
    if (ptr == size - 1) begin
      nxt = 0;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/queue_ptr_ctr.sv
// Wrapping BITS-wide pointer for the queue sequencer.
// Clear has priority over increment.
module queue_ptr_ctr
  import queue_ctrl_1r_1w_pkg::*;
#(
  parameter int unsigned BITS = 2,
  parameter int unsigned SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  output logic [BITS-1:0] ptr
);

  logic [BITS-1:0] ptr_nxt;
  logic [BITS-1:0] ptr_wrap;

  assign ptr_wrap =
    BITS'(ptr_inc(32'(ptr), SIZE));

  always_comb begin
    ptr_nxt = ptr;
    if (clr) begin
      ptr_nxt = '0;
    end else if (inc) begin
      ptr_nxt = ptr_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/queue_ctrl_1r_1w.sv
// Head/tail/occupancy sequencer for an external 1R/1W register-file queue.
// Define QUEUE_CTRL_AFULL_EN to add the out_afull port.
module queue_ctrl_1r_1w
  import queue_ctrl_1r_1w_pkg::*;
#(
  parameter int unsigned BITS         = 2,
  parameter int unsigned SIZE         = 4,
  parameter int unsigned AFULL_THRESH = 3,
  localparam int unsigned CW = cnt_width(BITS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_flush,
  input  logic            in_push_valid,
  output logic            out_push_ready,
  output logic            out_pop_valid,
  input  logic            in_pop_ready,
  output logic            out_wr_en,
  output logic [BITS-1:0] out_wr_addr,
  output logic [BITS-1:0] out_rd_addr,
  output logic [CW-1:0]   out_count,
  output logic            out_full,
`ifdef QUEUE_CTRL_AFULL_EN
  output logic            out_afull,
`endif
  output logic            out_empty
);

  if (SIZE < 2 || SIZE > (1 << BITS))
  begin : g_bad_size
    $error("queue_ctrl_1r_1w: bad SIZE");
  end

  if (AFULL_THRESH < 1 || AFULL_THRESH > SIZE)
  begin : g_bad_thresh
    $error("queue_ctrl_1r_1w: bad AFULL_THRESH");
  end

  logic [BITS-1:0] head;
  logic [BITS-1:0] tail;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic            push_fire;
  logic            pop_fire;

  assign out_full  = (count == CW'(SIZE));
  assign out_empty = (count == '0);

  assign out_push_ready = !out_full;
  assign out_pop_valid  = !out_empty;

  assign push_fire =
    in_push_valid & out_push_ready & !in_flush;
  assign pop_fire =
    out_pop_valid & in_pop_ready & !in_flush;

  assign out_wr_en   = push_fire;
  assign out_wr_addr = tail;
  assign out_rd_addr = head;
  assign out_count   = count;

`ifdef QUEUE_CTRL_AFULL_EN
  assign out_afull = (count >= CW'(AFULL_THRESH));
`endif

  queue_ptr_ctr #(
    .BITS (BITS),
    .SIZE (SIZE)
  ) u_head (
    .clk (clk),
    .rst (rst),
    .clr (in_flush),
    .inc (pop_fire),
    .ptr (head)
  );

  queue_ptr_ctr #(
    .BITS (BITS),
    .SIZE (SIZE)
  ) u_tail (
    .clk (clk),
    .rst (rst),
    .clr (in_flush),
    .inc (push_fire),
    .ptr (tail)
  );

  // Fires are already masked by flush, so arms stay exclusive
  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      in_flush:
        count_nxt = '0;
      push_fire && !pop_fire:
        count_nxt = count + 1'b1;
      pop_fire && !push_fire:
        count_nxt = count - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule
